// File: rtl/layer_mac_sched_if.sv
// Stream, ROM and result signals of the layer MAC scheduler, bundled for port use.
// master = surrounding environment, slave = scheduler.
interface layer_mac_sched_if #(
    parameter int N_IN = 15,
    parameter int DW   = 24,
    parameter int WAW  = 9,
    parameter int BAW  = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN*DW-1:0]   in_data;
    logic [WAW-1:0]       w_addr;
    logic [DW-1:0]        w_data;
    logic [BAW-1:0]       b_addr;
    logic [DW-1:0]        b_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [BAW-1:0]       out_idx;
    logic                 layer_done;

    modport master (
        output in_valid, in_data, w_data, b_data, out_ready,
        input  in_ready, w_addr, b_addr, out_valid, out_data, out_idx, layer_done
    );

    modport slave (
        input  in_valid, in_data, w_data, b_data, out_ready,
        output in_ready, w_addr, b_addr, out_valid, out_data, out_idx, layer_done
    );
endinterface

// File: rtl/layer_mac_sched.sv
// Time-multiplexed fully-connected layer: one shared MAC, neurons evaluated in turn.
// Optional LAYER_MAC_BUSY_CNT_EN adds a saturating busy_cycles counter.
//
// state | meaning
// IDLE  | waiting for an input vector (in_ready=1)
// MAC   | N_IN+1 cycles: issue weight reads, accumulate bias + w*a
// EMIT  | activated result held on out_* until accepted
module layer_mac_sched #(
    parameter int N_IN  = 15,
    parameter int N_OUT = 32,
    parameter int DW    = 24,
    parameter int WAW   = 9,
    parameter int BAW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    layer_mac_sched_if.slave  bus
`ifdef LAYER_MAC_BUSY_CNT_EN
    ,
    output logic [31:0]       busy_cycles
`endif
);
    localparam int CW = $clog2(N_IN + 1);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [BAW-1:0]  o_q, o_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [7:0]      act_q, act_d;
    logic            out_valid_q, out_valid_d;
    logic            layer_done_q, layer_done_d;
    logic            in_ready_q, in_ready_d;
    logic [WAW-1:0]  w_addr_q, w_addr_d;
    logic [BAW-1:0]  b_addr_q, b_addr_d;
    logic            latch;
    logic [DW-1:0]   vec_q [N_IN];
    logic [AW-1:0]   a_idx;
    logic [DW-1:0]   a_sel;
    logic [DW-1:0]   prod;

    function automatic logic [7:0] activate(input logic [DW-1:0] a);
        if (a[DW-1])
            return 8'd0;
        else if (a > DW'(4096))
            return 8'hFF;
        else
            return a[12:5];
    endfunction

    // Weight arriving in MAC cycle c belongs to activation c-1.
    always_comb begin
        a_idx = (c_q == '0) ? '0 : AW'(c_q - CW'(1));
        a_sel = vec_q[a_idx];
        prod  = bus.w_data * a_sel;
    end

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        o_d          = o_q;
        acc_d        = acc_q;
        act_d        = act_q;
        out_valid_d  = out_valid_q;
        layer_done_d = 1'b0;
        in_ready_d   = 1'b0;
        w_addr_d     = w_addr_q;
        b_addr_d     = b_addr_q;
        latch        = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    latch      = 1'b1;
                    in_ready_d = 1'b0;
                    o_d        = '0;
                    c_d        = '0;
                    w_addr_d   = '0;
                    b_addr_d   = '0;
                    state_d    = MAC;
                end
            end
            MAC: begin
                c_d = c_q + CW'(1);
                if (c_q < CW'(N_IN - 1))
                    w_addr_d = w_addr_q + WAW'(1);
                if (c_q == CW'(1))
                    acc_d = bus.b_data + prod;
                else if (c_q >= CW'(2))
                    acc_d = acc_q + prod;
                if (c_q == CW'(N_IN)) begin
                    c_d         = '0;
                    act_d       = activate(acc_d);
                    out_valid_d = 1'b1;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (o_q == BAW'(N_OUT - 1)) begin
                        layer_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        // Weights are laid out neuron-major, so the next neuron
                        // starts right after the last address issued.
                        o_d      = o_q + BAW'(1);
                        w_addr_d = w_addr_q + WAW'(1);
                        b_addr_d = o_q + BAW'(1);
                        c_d      = '0;
                        state_d  = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            c_q          <= '0;
            o_q          <= '0;
            acc_q        <= '0;
            act_q        <= '0;
            out_valid_q  <= 1'b0;
            layer_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
            w_addr_q     <= '0;
            b_addr_q     <= '0;
            for (int k = 0; k < N_IN; k++)
                vec_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            o_q          <= o_d;
            acc_q        <= acc_d;
            act_q        <= act_d;
            out_valid_q  <= out_valid_d;
            layer_done_q <= layer_done_d;
            in_ready_q   <= in_ready_d;
            w_addr_q     <= w_addr_d;
            b_addr_q     <= b_addr_d;
            if (latch) begin
                for (int k = 0; k < N_IN; k++)
                    vec_q[k] <= bus.in_data[k*DW +: DW];
            end
        end
    end

`ifdef LAYER_MAC_BUSY_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy_cycles <= '0;
        else if (state_q != IDLE && busy_cycles != '1)
            busy_cycles <= busy_cycles + 32'd1;
    end
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = {{(DW-8){1'b0}}, act_q};
    assign bus.out_idx    = o_q;
    assign bus.layer_done = layer_done_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.b_addr     = b_addr_q;
endmodule

// File: tb/tb_layer_mac_sched.sv
// Randomized bench for layer_mac_sched against a plain-arithmetic layer model.
module tb_layer_mac_sched;
    localparam int N_IN  = 15;
    localparam int N_OUT = 2;
    localparam int DW    = 24;
    localparam int WAW   = 9;
    localparam int BAW   = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cnt    = 0;
    int   layers_done = 0;

    logic [DW-1:0] wrom [2**WAW];
    logic [DW-1:0] brom [2**BAW];
    logic [DW-1:0] vec  [N_IN];
    logic [7:0]    res  [N_OUT];

    layer_mac_sched_if #(.N_IN(N_IN), .DW(DW), .WAW(WAW), .BAW(BAW)) bus ();

`ifdef LAYER_MAC_BUSY_CNT_EN
    logic [31:0] busy_cycles;
`endif

    layer_mac_sched #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WAW(WAW), .BAW(BAW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef LAYER_MAC_BUSY_CNT_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read ROMs plus cycle and layer_done bookkeeping.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        bus.w_data <= wrom[bus.w_addr];
        bus.b_data <= brom[bus.b_addr];
        if (bus.layer_done)
            done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd(input int lo, input int hi);
        int v;
        v = lo + int'($urandom_range(hi - lo, 0));
        return v[DW-1:0];
    endfunction

    // Expected activation of neuron o: modulo-2^DW dot product plus bias,
    // then negative -> 0, above 4096 -> 255, otherwise value / 32.
    function automatic longint ref_out(input int o);
        logic [DW-1:0] acc;
        int v;
        acc = brom[o];
        for (int i = 0; i < N_IN; i++)
            acc = acc + wrom[o*N_IN + i] * vec[i];
        v = int'($signed(acc));
        if (v < 0)    return 0;
        if (v > 4096) return 255;
        return longint'(v / 32);
    endfunction

    task automatic set_rand(input bit full);
        for (int i = 0; i < N_IN; i++) begin
            if (full)                          vec[i] = DW'($urandom);
            else if ($urandom_range(9, 0) == 0) vec[i] = rnd(-3000, 3000);
            else                               vec[i] = rnd(0, 40);
        end
        for (int k = 0; k < N_IN*N_OUT; k++)
            wrom[k] = full ? DW'($urandom) : rnd(-32, 32);
        for (int o = 0; o < N_OUT; o++)
            brom[o] = full ? DW'($urandom) : rnd(-2000, 6000);
    endtask

    task automatic send_vec(output int hs_cyc);
        int n;
        n = 0;
        hs_cyc = cyc;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_wait", 0, 1);
            return;
        end
        for (int i = 0; i < N_IN; i++)
            bus.in_data[i*DW +: DW] = vec[i];
        bus.in_valid = 1'b1;
        hs_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("in_ready_busy", longint'(bus.in_ready), 0);
    endtask

    task automatic run_layer(input bit bp, input int stall);
        int hs, n, dly, viol;
        logic [DW-1:0]  d0;
        logic [BAW-1:0] x0;
        logic [WAW-1:0] a0;
        send_vec(hs);
        for (int o = 0; o < N_OUT; o++) begin
            bus.out_ready = !bp;
            n = 0;
            while (!bus.out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!bus.out_valid) begin
                chk("out_valid_wait", 0, 1);
                return;
            end
            chk("latency", longint'(cyc - hs), N_IN + 2);
            chk("out_idx", longint'(bus.out_idx), o);
            chk("out_data", longint'(bus.out_data), ref_out(o));
            res[o] = bus.out_data[7:0];
            if (o == 0 && stall > 0) begin
                d0 = bus.out_data; x0 = bus.out_idx; a0 = bus.w_addr;
                viol = 0;
                repeat (stall) begin
                    @(negedge clk);
                    if (!bus.out_valid || bus.out_data != d0 || bus.out_idx != x0 ||
                        bus.w_addr != a0 || bus.in_ready)
                        viol++;
                end
                chk("stall_stable", viol, 0);
            end
            if (bp) begin
                dly = int'($urandom_range(3, 0));
                repeat (dly) @(negedge clk);
                bus.out_ready = 1'b1;
            end
            hs = cyc;
            @(negedge clk);
            bus.out_ready = !bp;
            chk("layer_done", longint'(bus.layer_done), (o == N_OUT - 1) ? 1 : 0);
            chk("out_valid_drop", longint'(bus.out_valid), 0);
        end
        layers_done++;
        chk("in_ready_at_done", longint'(bus.in_ready), 0);
        @(negedge clk);
        chk("in_ready_after_done", longint'(bus.in_ready), 1);
        chk("done_count", done_cnt, layers_done);
    endtask

    task automatic reset_mid_mac();
        int hs;
        set_rand(1'b0);
        send_vec(hs);
        repeat (5) @(negedge clk);
        chk("w_addr_mac5", longint'(bus.w_addr), 5);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_out_idx", longint'(bus.out_idx), 0);
        chk("rst_layer_done", longint'(bus.layer_done), 0);
        chk("rst_w_addr", longint'(bus.w_addr), 0);
        chk("rst_b_addr", longint'(bus.b_addr), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", longint'(bus.in_ready), 1);
        run_layer(1'b1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2**WAW; k++) wrom[k] = '0;
        for (int k = 0; k < 2**BAW; k++) brom[k] = '0;
        for (int i = 0; i < N_IN; i++)   vec[i]  = '0;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", longint'(bus.in_ready), 0);
        chk("reset_out_valid", longint'(bus.out_valid), 0);
        chk("reset_out_data", longint'(bus.out_data), 0);
        chk("reset_layer_done", longint'(bus.layer_done), 0);
        chk("reset_w_addr", longint'(bus.w_addr), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("release_in_ready", longint'(bus.in_ready), 1);

        // zero weights: result is bias/32, negative bias clamps to 0
        for (int i = 0; i < N_IN; i++) vec[i] = DW'($urandom);
        brom[0] = DW'(1000);
        brom[1] = DW'(-5);
        run_layer(1'b0, 0);
        chk("t_bias_n0", longint'(res[0]), 31);
        chk("t_bias_n1", longint'(res[1]), 0);

        // activation boundary at 4096
        for (int i = 0; i < N_IN; i++) vec[i] = DW'(1);
        wrom[0]    = DW'(256);
        wrom[N_IN] = DW'(256);
        brom[0]    = DW'(3840);
        brom[1]    = DW'(3841);
        run_layer(1'b1, 0);
        chk("t_4096", longint'(res[0]), 128);
        chk("t_4097", longint'(res[1]), 255);

        // ramp weights: 2*(1+..+15) = 240 -> 7
        for (int i = 0; i < N_IN; i++) vec[i] = DW'(2);
        for (int o = 0; o < N_OUT; o++) begin
            brom[o] = '0;
            for (int i = 0; i < N_IN; i++) wrom[o*N_IN + i] = DW'(i + 1);
        end
        run_layer(1'b0, 0);
        chk("t_ramp_n0", longint'(res[0]), 7);
        chk("t_ramp_n1", longint'(res[1]), 7);

        set_rand(1'b0);
        run_layer(1'b1, 20);

        reset_mid_mac();

        set_rand(1'b0);
        run_layer(1'b0, 0);
        set_rand(1'b0);
        run_layer(1'b0, 0);

        for (int k = 0; k < 10; k++) begin
            set_rand(k % 4 == 3);
            run_layer(1'b1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
